// File: rtl/botoes_codificador.sv
// Button front end: two-flop synchroniser, whole-vector debounce and one-hot to
// 1-based index encoder. Emits one pulse per press/release cycle.
module botoes_codificador #(
  parameter int N_BOTOES        = 9,
  parameter int LARGURA         = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic [LARGURA-1:0]  binario,
  output logic                jogada_valida,
  output logic                erro_multiplo,
  output logic                ocupado
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

  typedef enum logic [1:0] {OCIOSO, EMITE, ERRO, ESPERA_SOLTAR} estado_t;

  logic [N_BOTOES-1:0] meta, sinc, ultimo;
  logic [CW-1:0]       cont;
  logic                estavel, um_so;
  logic [LARGURA-1:0]  indice;
  estado_t             estado, prox;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      sinc <= '0;
    end else begin
      meta <= botoes;
      sinc <= meta;
    end
  end

  // Any change anywhere in the vector restarts the window; count saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ultimo <= '0;
      cont   <= '0;
    end else if (sinc != ultimo) begin
      ultimo <= sinc;
      cont   <= '0;
    end else if (cont < CW'(DEBOUNCE_CICLOS)) begin
      cont <= cont + 1'b1;
    end
  end

  assign estavel = (cont == CW'(DEBOUNCE_CICLOS));
  assign um_so   = (ultimo != '0) && ((ultimo & (ultimo - N_BOTOES'(1))) == '0);

  always_comb begin
    indice = '0;
    for (int i = 0; i < N_BOTOES; i++)
      if (ultimo[i]) indice = LARGURA'(i + 1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:
        if (habilita && estavel && ultimo != '0)
          prox = um_so ? EMITE : ERRO;
      EMITE:         prox = ESPERA_SOLTAR;
      ERRO:          prox = ESPERA_SOLTAR;
      ESPERA_SOLTAR: if (estavel && ultimo == '0) prox = OCIOSO;
      default:       prox = OCIOSO;
    endcase
  end

  // Index is latched on the edge that enters EMITE, so it is valid with the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                binario <= '0;
    else if (estado == OCIOSO && prox == EMITE) binario <= indice;
  end

  always_comb begin
    jogada_valida = (estado == EMITE);
    erro_multiplo = (estado == ERRO);
    ocupado       = (estado != OCIOSO);
  end
endmodule

// File: tb/tb_botoes_codificador.sv
// Directed bench for botoes_codificador with a window-based reference model
// compared every cycle, plus literal timing/value checks.
module tb_botoes_codificador;
  localparam int N = 9;
  localparam int L = 4;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] botoes = '0;
  logic         habilita = 1'b0;
  logic [L-1:0] binario;
  logic         jogada_valida, erro_multiplo, ocupado;

  int errors = 0;
  int checks = 0;

  botoes_codificador #(.N_BOTOES(N), .LARGURA(L), .DEBOUNCE_CICLOS(D)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
    .binario(binario), .jogada_valida(jogada_valida),
    .erro_multiplo(erro_multiplo), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples kept newest-first; the vector is stable when
  // the samples two to two+D edges old all agree and D edges have passed since reset.
  logic [N-1:0] q[$];
  int           t;
  bit           stab;
  logic [N-1:0] val;
  int           phase;  // 0 idle, 1 pulse, 2 waiting for release
  logic [L-1:0] m_bin;
  bit           m_jv, m_em;

  task automatic model_reset();
    q.delete();
    for (int j = 0; j < D + 3; j++) q.push_back('0);
    t = 0; stab = 0; val = '0; phase = 0; m_bin = '0; m_jv = 0; m_em = 0;
  endtask

  initial model_reset();

  always @(posedge clock) begin
    logic [N-1:0] b;
    logic         h;
    b = botoes;
    h = habilita;
    if (!reset) model_reset();
    else begin
      m_jv = 0; m_em = 0;
      case (phase)
        0: if (h && stab && val != '0) begin
             if ($countones(val) == 1) begin
               m_jv  = 1;
               m_bin = L'($clog2(val) + 1);
             end else m_em = 1;
             phase = 1;
           end
        1: phase = 2;
        default: if (stab && val == '0) phase = 0;
      endcase
      t++;
      q.push_front(b);
      void'(q.pop_back());
      val  = q[2];
      stab = (t >= D);
      for (int j = 2; j <= 2 + D; j++) if (q[j] != q[2]) stab = 0;
    end
    #1;
    check("cyc_binario", binario, m_bin);
    check("cyc_jogada_valida", jogada_valida, m_jv);
    check("cyc_erro_multiplo", erro_multiplo, m_em);
    check("cyc_ocupado", ocupado, phase != 0);
  end

  task automatic count_pulses(input int n, output int jv, output int em);
    jv = 0; em = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (jogada_valida) jv++;
      if (erro_multiplo) em++;
    end
  endtask

  initial begin
    int jv, em, n;
    habilita = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_binario", binario, 0);
    check("rst_ocupado", ocupado, 0);
    reset = 1'b1;

    count_pulses(20, jv, em);
    check("idle_jv", jv, 0);
    check("idle_em", em, 0);
    check("idle_binario", binario, 0);
    check("idle_ocupado", ocupado, 0);

    // single press of bit 4: pulse exactly after the 8th edge from the drive
    botoes = 9'b000010000;
    repeat (7) @(negedge clock);
    check("p5_before", jogada_valida, 0);
    @(negedge clock);
    check("p5_pulse", jogada_valida, 1);
    check("p5_binario", binario, 5);
    @(negedge clock);
    check("p5_after", jogada_valida, 0);
    repeat (12) @(negedge clock);
    botoes = '0;
    repeat (7) @(negedge clock);
    check("rel_ocupado_hi", ocupado, 1);
    @(negedge clock);
    check("rel_ocupado_lo", ocupado, 0);
    check("rel_binario_held", binario, 5);

    // two buttons: one error pulse, index unchanged
    botoes = 9'b100000001;
    count_pulses(20, jv, em);
    check("multi_jv", jv, 0);
    check("multi_em", em, 1);
    check("multi_binario", binario, 5);
    botoes = '0;
    repeat (12) @(negedge clock);

    botoes = 9'b100000000;
    count_pulses(15, jv, em);
    check("p9_jv", jv, 1);
    check("p9_binario", binario, 9);
    botoes = '0;
    repeat (12) @(negedge clock);

    // bounce on bit 0, then held: timing measured from the last toggle
    for (int k = 0; k < 4; k++) begin
      botoes = (k % 2 == 0) ? 9'b1 : 9'b0;
      repeat (2) @(negedge clock);
    end
    botoes = 9'b1;
    n = 0;
    while (!jogada_valida && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("bounce_latency", n, 8);
    check("bounce_binario", binario, 1);
    count_pulses(10, jv, em);
    check("bounce_extra", jv + em, 0);
    botoes = '0;
    repeat (12) @(negedge clock);

    // held while disabled, accepted the cycle after habilita rises
    habilita = 1'b0;
    botoes = 9'b000000100;
    count_pulses(20, jv, em);
    check("dis_jv", jv, 0);
    habilita = 1'b1;
    @(negedge clock);
    check("en_pulse", jogada_valida, 1);
    check("en_binario", binario, 3);
    botoes = 9'b000000110;
    count_pulses(20, jv, em);
    check("extra_ignored", jv + em, 0);
    check("extra_ocupado", ocupado, 1);
    botoes = '0;
    repeat (12) @(negedge clock);

    // reset one cycle before EMITE aborts; the press is re-debounced afterwards
    botoes = 9'b000001000;
    repeat (7) @(negedge clock);
    check("pre_rst_ocupado", ocupado, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_binario", binario, 0);
    check("mid_rst_jv", jogada_valida, 0);
    check("mid_rst_em", erro_multiplo, 0);
    check("mid_rst_ocupado", ocupado, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    count_pulses(20, jv, em);
    check("post_rst_jv", jv, 1);
    check("post_rst_binario", binario, 4);
    botoes = '0;
    repeat (12) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
